// File: rtl/vpu_rd_pkg.sv
// Shared definitions for the source burst reader: channel FSM encoding and
// default geometry of the SRAM read path.
package vpu_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  localparam int DEF_R_PORT_CNT     = 3;
  localparam int DEF_BANK_CNT_LG2   = 2;
  localparam int DEF_BANK_DEPTH_LG2 = 10;
  localparam int DEF_DATA_WIDTH     = 512;
  localparam int DEF_LEN_W          = 8;
  localparam int DEF_FIFO_DEPTH     = 4;

endpackage

// File: rtl/vpu_rd_channel.sv
// One independent read channel: command capture, bank request, credit-limited
// beat issue, outstanding tracking and an in-order return FIFO.
module vpu_rd_channel
  import vpu_rd_pkg::*;
#(
  parameter int BANK_CNT_LG2   = DEF_BANK_CNT_LG2,
  parameter int BANK_DEPTH_LG2 = DEF_BANK_DEPTH_LG2,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [BANK_CNT_LG2-1:0]   cmd_id_i,
  input  logic [BANK_DEPTH_LG2-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]          cmd_len_i,
  output logic                      rreq_o,
  output logic [BANK_CNT_LG2-1:0]   rid_o,
  output logic [BANK_DEPTH_LG2-1:0] raddr_o,
  output logic                      reb_o,
  output logic                      rlast_o,
  input  logic                      rack_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      rvalid_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic                      out_last_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rd_state_e                 state;
  logic [BANK_CNT_LG2-1:0]   id_r;
  logic [BANK_DEPTH_LG2-1:0] addr_r;
  logic [LEN_W-1:0]          len_r;
  logic [LEN_W-1:0]          beat_cnt;
  logic [LEN_W-1:0]          ret_cnt;
  logic [CNT_W-1:0]          outstanding;
  logic [CNT_W-1:0]          out_nxt;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [DATA_WIDTH-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     last_mem;
  logic                      credit;
  logic                      rv_acc;
  logic                      push;
  logic                      pop;

  // A beat may only be issued if its return is guaranteed a FIFO slot.
  assign credit      = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < (CNT_W+1)'(FIFO_DEPTH);
  assign reb_o       = (state == ST_READ) && credit;
  assign rlast_o     = reb_o && (beat_cnt == len_r);
  assign rreq_o      = (state == ST_REQ) || (state == ST_READ);
  assign rid_o       = id_r;
  assign raddr_o     = addr_r;
  assign busy_o      = (state != ST_IDLE);
  assign cmd_ready_o = rst_n && (state == ST_IDLE);

  // Returns with nothing in flight (e.g. after a reset mid-burst) are dropped.
  assign rv_acc      = rvalid_i && (outstanding != '0);
  assign push        = rv_acc;
  assign out_valid_o = (fifo_cnt != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = data_mem[rd_ptr];
  assign out_last_o  = out_valid_o && last_mem[rd_ptr];
  assign out_nxt     = outstanding + CNT_W'(reb_o) - CNT_W'(rv_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      id_r        <= '0;
      addr_r      <= '0;
      len_r       <= '0;
      beat_cnt    <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_nxt;
      fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        ret_cnt <= ret_cnt + LEN_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            id_r     <= cmd_id_i;
            addr_r   <= cmd_addr_i;
            len_r    <= cmd_len_i;
            beat_cnt <= '0;
            ret_cnt  <= '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rack_i) state <= ST_READ;
        end
        ST_READ: begin
          if (reb_o) begin
            addr_r   <= addr_r + BANK_DEPTH_LG2'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (rlast_o) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave as soon as the final return lands, not a cycle later.
          if (out_nxt == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rdata_i;
      last_mem[wr_ptr] <= (ret_cnt == len_r);
    end
  end

endmodule

// File: rtl/vpu_src_burst_reader.sv
// Multi-channel SRAM burst reader: R_PORT_CNT independent channels, each
// turning a (bank, start, length) command into a flow-controlled beat stream.
module vpu_src_burst_reader
  import vpu_rd_pkg::*;
#(
  parameter int R_PORT_CNT     = DEF_R_PORT_CNT,
  parameter int BANK_CNT_LG2   = DEF_BANK_CNT_LG2,
  parameter int BANK_DEPTH_LG2 = DEF_BANK_DEPTH_LG2,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [R_PORT_CNT-1:0]                cmd_valid_i,
  output logic [R_PORT_CNT-1:0]                cmd_ready_o,
  input  logic [BANK_CNT_LG2*R_PORT_CNT-1:0]   cmd_id_i,
  input  logic [BANK_DEPTH_LG2*R_PORT_CNT-1:0] cmd_addr_i,
  input  logic [LEN_W*R_PORT_CNT-1:0]          cmd_len_i,
  output logic [R_PORT_CNT-1:0]                rreq_o,
  output logic [BANK_CNT_LG2*R_PORT_CNT-1:0]   rid_o,
  output logic [BANK_DEPTH_LG2*R_PORT_CNT-1:0] raddr_o,
  output logic [R_PORT_CNT-1:0]                reb_o,
  output logic [R_PORT_CNT-1:0]                rlast_o,
  input  logic [R_PORT_CNT-1:0]                rack_i,
  input  logic [DATA_WIDTH*R_PORT_CNT-1:0]     rdata_i,
  input  logic [R_PORT_CNT-1:0]                rvalid_i,
  output logic [R_PORT_CNT-1:0]                out_valid_o,
  input  logic [R_PORT_CNT-1:0]                out_ready_i,
  output logic [DATA_WIDTH*R_PORT_CNT-1:0]     out_data_o,
  output logic [R_PORT_CNT-1:0]                out_last_o,
  output logic [R_PORT_CNT-1:0]                busy_o
);

  for (genvar i = 0; i < R_PORT_CNT; i++) begin : g_ch
    vpu_rd_channel #(
      .BANK_CNT_LG2  (BANK_CNT_LG2),
      .BANK_DEPTH_LG2(BANK_DEPTH_LG2),
      .DATA_WIDTH    (DATA_WIDTH),
      .LEN_W         (LEN_W),
      .FIFO_DEPTH    (FIFO_DEPTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid_i(cmd_valid_i[i]),
      .cmd_ready_o(cmd_ready_o[i]),
      .cmd_id_i   (cmd_id_i[i*BANK_CNT_LG2 +: BANK_CNT_LG2]),
      .cmd_addr_i (cmd_addr_i[i*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2]),
      .cmd_len_i  (cmd_len_i[i*LEN_W +: LEN_W]),
      .rreq_o     (rreq_o[i]),
      .rid_o      (rid_o[i*BANK_CNT_LG2 +: BANK_CNT_LG2]),
      .raddr_o    (raddr_o[i*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2]),
      .reb_o      (reb_o[i]),
      .rlast_o    (rlast_o[i]),
      .rack_i     (rack_i[i]),
      .rdata_i    (rdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .rvalid_i   (rvalid_i[i]),
      .out_valid_o(out_valid_o[i]),
      .out_ready_i(out_ready_i[i]),
      .out_data_o (out_data_o[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_last_o (out_last_o[i]),
      .busy_o     (busy_o[i])
    );
  end

endmodule

// File: tb/tb_vpu_src_burst_reader.sv
// Bench for vpu_src_burst_reader: per-channel SRAM responder and stream sink
// with scoreboard queues filled at command time and drained as beats appear.
module tb_vpu_src_burst_reader;

  localparam int NCH = 3;
  localparam int BW  = 2;
  localparam int AW  = 10;
  localparam int DW  = 512;
  localparam int LW  = 8;
  localparam int FD  = 4;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    cmd_valid_i;
  logic [NCH-1:0]    cmd_ready_o;
  logic [BW*NCH-1:0] cmd_id_i;
  logic [AW*NCH-1:0] cmd_addr_i;
  logic [LW*NCH-1:0] cmd_len_i;
  logic [NCH-1:0]    rreq_o;
  logic [BW*NCH-1:0] rid_o;
  logic [AW*NCH-1:0] raddr_o;
  logic [NCH-1:0]    reb_o;
  logic [NCH-1:0]    rlast_o;
  logic [NCH-1:0]    rack_i;
  logic [DW*NCH-1:0] rdata_i;
  logic [NCH-1:0]    rvalid_i;
  logic [NCH-1:0]    out_valid_o;
  logic [NCH-1:0]    out_ready_i;
  logic [DW*NCH-1:0] out_data_o;
  logic [NCH-1:0]    out_last_o;
  logic [NCH-1:0]    busy_o;

  vpu_src_burst_reader #(
    .R_PORT_CNT(NCH), .BANK_CNT_LG2(BW), .BANK_DEPTH_LG2(AW),
    .DATA_WIDTH(DW), .LEN_W(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_id_i(cmd_id_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .rreq_o(rreq_o), .rid_o(rid_o), .raddr_o(raddr_o), .reb_o(reb_o), .rlast_o(rlast_o),
    .rack_i(rack_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] id;
    logic          last;
  } beat_t;

  beat_t exp_rd  [NCH][$];
  beat_t exp_out [NCH][$];
  beat_t pend    [NCH][$];

  int checks, failures, cyc;
  int rv_pct, or_pct, rack_dly;
  int stray [NCH];
  int iss_cnt [NCH];
  int req_cyc [NCH];
  int last_rv_cyc [NCH];
  int busy_fall_cyc [NCH];
  logic [NCH-1:0] busy_prev;

  function automatic logic [DW-1:0] sram_word(int ch, logic [BW-1:0] id, logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = {4'(ch), 2'b00, id, 8'(k), 6'b0, a};
    return w;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM responder and stream sink, one pass per negative edge.
  initial begin
    beat_t mb;
    beat_t mo;
    rack_i = '0; rvalid_i = '0; rdata_i = '0; out_ready_i = '0;
    busy_prev = '0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!rst_n) begin
          rack_i[ch] = 1'b0; rvalid_i[ch] = 1'b0; out_ready_i[ch] = 1'b0;
          req_cyc[ch] = 0; busy_prev[ch] = 1'b0;
        end else begin
          rvalid_i[ch] = 1'b0;
          if (stray[ch] > 0) begin
            rvalid_i[ch] = 1'b1;
            rdata_i[ch*DW +: DW] = ~sram_word(ch, '0, '0);
            stray[ch]--;
          end else if (pend[ch].size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            mb = pend[ch].pop_front();
            rvalid_i[ch] = 1'b1;
            rdata_i[ch*DW +: DW] = sram_word(ch, mb.id, mb.addr);
            if (mb.last) last_rv_cyc[ch] = cyc;
          end
          if (reb_o[ch]) begin
            checks++;
            if (exp_rd[ch].size() == 0) begin
              failures++;
              $display("FAIL reb_unexpected ch%0d raddr=%h rlast=%b required no beat", ch,
                       raddr_o[ch*AW +: AW], rlast_o[ch]);
            end else begin
              mb = exp_rd[ch].pop_front();
              if (raddr_o[ch*AW +: AW] !== mb.addr || rid_o[ch*BW +: BW] !== mb.id ||
                  rlast_o[ch] !== mb.last) begin
                failures++;
                $display("FAIL reb_beat ch%0d raddr=%h rid=%h rlast=%b required raddr=%h rid=%h rlast=%b",
                         ch, raddr_o[ch*AW +: AW], rid_o[ch*BW +: BW], rlast_o[ch],
                         mb.addr, mb.id, mb.last);
              end
            end
            iss_cnt[ch]++;
            mb.addr = raddr_o[ch*AW +: AW];
            mb.id   = rid_o[ch*BW +: BW];
            mb.last = rlast_o[ch];
            pend[ch].push_back(mb);
          end
          if (rreq_o[ch]) begin
            rack_i[ch] = (req_cyc[ch] >= rack_dly);
            req_cyc[ch]++;
          end else begin
            rack_i[ch] = 1'b0;
            req_cyc[ch] = 0;
          end
          if (busy_prev[ch] && !busy_o[ch]) busy_fall_cyc[ch] = cyc;
          busy_prev[ch] = busy_o[ch];
          out_ready_i[ch] = int'($urandom_range(99)) < or_pct;
          if (out_valid_o[ch] && out_ready_i[ch]) begin
            checks++;
            if (exp_out[ch].size() == 0) begin
              failures++;
              $display("FAIL out_unexpected ch%0d data[31:0]=%h last=%b required no beat", ch,
                       out_data_o[ch*DW +: 32], out_last_o[ch]);
            end else begin
              mo = exp_out[ch].pop_front();
              if (out_data_o[ch*DW +: DW] !== sram_word(ch, mo.id, mo.addr) ||
                  out_last_o[ch] !== mo.last) begin
                failures++;
                $display("FAIL out_beat ch%0d data[31:0]=%h last=%b required data[31:0]=%h last=%b",
                         ch, out_data_o[ch*DW +: 32], out_last_o[ch],
                         sram_word(ch, mo.id, mo.addr) & 512'hFFFF_FFFF, mo.last);
              end
            end
          end
        end
      end
    end
  end

  task automatic send_cmd(int ch, logic [BW-1:0] id, logic [AW-1:0] addr, int len);
    int n;
    beat_t b;
    n = 0;
    while (!cmd_ready_o[ch] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o[ch]) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout ch%0d cmd_ready=0 required 1", ch);
      return;
    end
    cmd_valid_i[ch] = 1'b1;
    cmd_id_i[ch*BW +: BW]   = id;
    cmd_addr_i[ch*AW +: AW] = addr;
    cmd_len_i[ch*LW +: LW]  = LW'(len);
    for (int i = 0; i <= len; i++) begin
      b.addr = addr + AW'(i);
      b.id   = id;
      b.last = (i == len);
      exp_rd[ch].push_back(b);
      exp_out[ch].push_back(b);
    end
    @(negedge clk);
    cmd_valid_i[ch] = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = 1'b1;
      for (int ch = 0; ch < NCH; ch++)
        if (exp_rd[ch].size() != 0 || exp_out[ch].size() != 0 || pend[ch].size() != 0 ||
            busy_o[ch] || out_valid_o[ch]) done = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout busy=%b out_valid=%b required all idle within %0d cycles",
               busy_o, out_valid_o, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rreq_o, reb_o, rlast_o, out_valid_o, out_last_o, busy_o, rid_o, raddr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rreq=%b reb=%b rlast=%b oval=%b olast=%b busy=%b rid=%h raddr=%h required all 0",
               rreq_o, reb_o, rlast_o, out_valid_o, out_last_o, busy_o, rid_o, raddr_o);
    end
    checks++;
    if (cmd_ready_o !== 3'b000) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b required 000", cmd_ready_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready_o !== 3'b111) begin
      failures++;
      $display("FAIL post_reset_cmd_ready got=%b required 111", cmd_ready_o);
    end
  endtask

  task automatic test_basic();
    int base;
    rack_dly = 2; rv_pct = 100; or_pct = 100;
    @(negedge clk);
    base = iss_cnt[0];
    send_cmd(0, 2'd2, 10'h010, 3);
    wait_done(100);
    checks++;
    if (iss_cnt[0] - base !== 4) begin
      failures++;
      $display("FAIL basic_beats got=%0d required 4", iss_cnt[0] - base);
    end
    checks++;
    if (busy_fall_cyc[0] - last_rv_cyc[0] !== 1) begin
      failures++;
      $display("FAIL basic_busy_drop got=%0d cycles required 1", busy_fall_cyc[0] - last_rv_cyc[0]);
    end
  endtask

  task automatic test_wrap();
    int base;
    rack_dly = 0;
    base = iss_cnt[1];
    send_cmd(1, 2'd1, 10'h3FE, 3);
    wait_done(100);
    checks++;
    if (iss_cnt[1] - base !== 4) begin
      failures++;
      $display("FAIL wrap_beats got=%0d required 4", iss_cnt[1] - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    or_pct = 0; rv_pct = 100; rack_dly = 1;
    base = iss_cnt[2];
    send_cmd(2, 2'd3, 10'h020, 15);
    repeat (20) @(negedge clk);
    checks++;
    if (iss_cnt[2] - base !== FD) begin
      failures++;
      $display("FAIL bp_stall_beats got=%0d required %0d", iss_cnt[2] - base, FD);
    end
    checks++;
    if (out_valid_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL bp_out_valid got=%b required 1", out_valid_o[2]);
    end
    or_pct = 100;
    wait_done(200);
    checks++;
    if (iss_cnt[2] - base !== 16) begin
      failures++;
      $display("FAIL bp_total_beats got=%0d required 16", iss_cnt[2] - base);
    end
  endtask

  task automatic test_single();
    int base;
    rack_dly = 0; rv_pct = 100; or_pct = 100;
    base = iss_cnt[0];
    send_cmd(0, 2'd0, 10'h155, 0);
    wait_done(100);
    checks++;
    if (iss_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL single_beats got=%0d required 1", iss_cnt[0] - base);
    end
  endtask

  task automatic test_parallel();
    logic [AW-1:0] a [6];
    for (int i = 0; i < 6; i++) a[i] = AW'($urandom_range(1023));
    rack_dly = int'($urandom_range(3)); rv_pct = 60; or_pct = 50;
    fork
      begin send_cmd(0, 2'd1, a[0], 5);  send_cmd(0, 2'd3, a[1], 12); end
      begin send_cmd(1, 2'd2, a[2], 9);  send_cmd(1, 2'd0, a[3], 0);  end
      begin send_cmd(2, 2'd3, a[4], 2);  send_cmd(2, 2'd1, a[5], 7);  end
    join
    wait_done(3000);
  endtask

  task automatic test_mid_reset();
    int base;
    int n;
    rack_dly = 0; rv_pct = 100; or_pct = 0;
    send_cmd(0, 2'd1, 10'h100, 1);
    n = 0;
    while ((busy_o[0] || pend[0].size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    rv_pct = 0;
    base = iss_cnt[0];
    send_cmd(0, 2'd1, 10'h200, 7);
    repeat (10) @(negedge clk);
    checks++;
    if (iss_cnt[0] - base !== 2 || pend[0].size() !== 2) begin
      failures++;
      $display("FAIL midrst_outstanding issued=%0d pending=%0d required 2 and 2",
               iss_cnt[0] - base, pend[0].size());
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rreq_o, reb_o, rlast_o, out_valid_o, out_last_o, busy_o, rid_o, raddr_o, cmd_ready_o} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs rreq=%b reb=%b rlast=%b oval=%b olast=%b busy=%b rid=%h raddr=%h rdy=%b required all 0",
               rreq_o, reb_o, rlast_o, out_valid_o, out_last_o, busy_o, rid_o, raddr_o, cmd_ready_o);
    end
    rst_n = 1'b1;
    exp_rd[0].delete();
    exp_out[0].delete();
    pend[0].delete();
    #1;
    checks++;
    if (cmd_ready_o !== 3'b111) begin
      failures++;
      $display("FAIL midrst_cmd_ready got=%b required 111", cmd_ready_o);
    end
    rv_pct = 100; or_pct = 100;
    stray[0] = 2;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stray out_valid=%b busy=%b required 0 0", out_valid_o[0], busy_o[0]);
    end
    base = iss_cnt[0];
    send_cmd(0, 2'd2, 10'h050, 2);
    wait_done(100);
    checks++;
    if (iss_cnt[0] - base !== 3) begin
      failures++;
      $display("FAIL midrst_next_cmd beats=%0d required 3", iss_cnt[0] - base);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    cmd_valid_i = '0; cmd_id_i = '0; cmd_addr_i = '0; cmd_len_i = '0;
    rv_pct = 100; or_pct = 100; rack_dly = 0;
    for (int i = 0; i < NCH; i++) begin
      stray[i] = 0; iss_cnt[i] = 0; req_cyc[i] = 0;
      last_rv_cyc[i] = 0; busy_fall_cyc[i] = 0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_single();
    test_parallel();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
